// File: rtl/sym_ib_pkg.sv
// Shared definitions for the symmetric VN IB LUT bank: geometry and the loader state encoding.
package sym_ib_pkg;

  localparam int LUT_ADDR_W = 7;
  localparam int LUT_DATA_W = 4;
  localparam int LUT_DEPTH  = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } lut_ld_state_e;

  // Only a load that has not yet presented its final write can be cancelled.
  function automatic logic ld_abortable(lut_ld_state_e s);
    return (s == ST_DRAIN) || (s == ST_LOAD);
  endfunction

endpackage

// File: rtl/sym_vn_lut_wr_pipe.sv
// Registered LUT bank write stage: one-cycle latency from an accepted config word to the
// bank write port. A word accepted in the same cycle as an abort is dropped.
module sym_vn_lut_wr_pipe #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              hs,
  input  logic              abort,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              we,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] lut_in
);

  logic wr_ok;
  assign wr_ok = hs & ~abort;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we         <= 1'b0;
      write_addr <= '0;
      lut_in     <= '0;
    end else begin
      we <= wr_ok;
      if (wr_ok) begin
        write_addr <= addr;
        lut_in     <= data;
      end
    end
  end

endmodule

// File: rtl/sym_vn_lut_loader.sv
// Reload sequencer for one symmetric VN IB LUT bank. Optional SYM_VN_LUT_CHECKSUM_EN adds an
// unsigned-sum integrity check of the streamed entries before the bank is declared valid.
module sym_vn_lut_loader
  import sym_ib_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_W,
  parameter int DATA_W = LUT_DATA_W,
  parameter int DEPTH  = LUT_DEPTH,
  parameter int ITER_W = 5
) (
  input  logic              write_clk,
  input  logic              rstn,
  input  logic              load_start,
  input  logic [ITER_W-1:0] load_iter,
  input  logic              load_abort,
  input  logic              rd_busy,
  input  logic              cfg_valid,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic [ITER_W-1:0] cfg_iter,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic              we,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] lut_in,
  output logic              rd_grant,
  output logic              load_busy,
  output logic              load_done,
  output logic              lut_valid
`ifdef SYM_VN_LUT_CHECKSUM_EN
  ,input  logic [DATA_W+ADDR_W-1:0] cfg_checksum
  ,output logic                     chk_err
`endif
);

  lut_ld_state_e     state, nxt;
  logic [ADDR_W-1:0] idx;
  logic              hs, abort_eff, last, start_acc, chk_ok;

  // Grant is a pure function of state, so it falls one cycle after load_start and any
  // read granted alongside load_start is covered by the DRAIN wait on rd_busy.
  assign rd_grant  = (state == ST_IDLE);
  assign load_busy = (state != ST_IDLE);
  assign cfg_ready = (state == ST_LOAD);
  assign load_done = (state == ST_DONE);
  assign cfg_addr  = idx;

  assign hs        = cfg_valid & cfg_ready;
  assign abort_eff = load_abort & ld_abortable(state);
  assign last      = (idx == ADDR_W'(DEPTH - 1));
  assign start_acc = (state == ST_IDLE) & load_start;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (load_start) nxt = ST_DRAIN;
      ST_DRAIN: if (abort_eff) nxt = ST_IDLE;
                else if (!rd_busy) nxt = ST_LOAD;
      ST_LOAD:  if (abort_eff) nxt = ST_IDLE;
                else if (hs && last) nxt = ST_DONE;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cfg_iter  <= '0;
      lut_valid <= 1'b0;
    end else begin
      state <= nxt;
      if (start_acc) begin
        cfg_iter  <= load_iter;
        lut_valid <= 1'b0;
        idx       <= '0;
      end
      // Index parks on the last entry; it is never wrapped back onto live addresses.
      if (hs && !abort_eff && !last) idx <= idx + ADDR_W'(1);
      if (state == ST_DONE) lut_valid <= chk_ok;
    end
  end

`ifdef SYM_VN_LUT_CHECKSUM_EN
  localparam int CHK_W = DATA_W + ADDR_W;
  logic [CHK_W-1:0] sum;

  assign chk_ok = (sum == cfg_checksum);

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      sum     <= '0;
      chk_err <= 1'b0;
    end else if (start_acc) begin
      sum     <= '0;
      chk_err <= 1'b0;
    end else begin
      if (hs) sum <= sum + CHK_W'(cfg_data);
      if (state == ST_DONE && !chk_ok) chk_err <= 1'b1;
    end
  end
`else
  assign chk_ok = 1'b1;
`endif

  sym_vn_lut_wr_pipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_pipe (
    .clk        (write_clk),
    .rstn       (rstn),
    .hs         (hs),
    .abort      (abort_eff),
    .addr       (idx),
    .data       (cfg_data),
    .we         (we),
    .write_addr (write_addr),
    .lut_in     (lut_in)
  );

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// Randomized self-checking bench for sym_vn_lut_loader against a spec-level loader model.
module tb_sym_vn_lut_loader;

  logic       write_clk = 1'b0;
  logic       rstn;
  logic       load_start, load_abort, rd_busy, cfg_valid;
  logic [4:0] load_iter;
  logic [3:0] cfg_data;
  logic       cfg_ready, we, rd_grant, load_busy, load_done, lut_valid;
  logic [4:0] cfg_iter;
  logic [6:0] cfg_addr, write_addr;
  logic [3:0] lut_in;
`ifdef SYM_VN_LUT_CHECKSUM_EN
  logic [10:0] cfg_checksum;
  logic        chk_err;
`endif

  always #5 write_clk = ~write_clk;

  sym_vn_lut_loader dut (
    .write_clk (write_clk), .rstn (rstn), .load_start (load_start), .load_iter (load_iter),
    .load_abort (load_abort), .rd_busy (rd_busy), .cfg_valid (cfg_valid), .cfg_data (cfg_data),
    .cfg_ready (cfg_ready), .cfg_iter (cfg_iter), .cfg_addr (cfg_addr), .we (we),
    .write_addr (write_addr), .lut_in (lut_in), .rd_grant (rd_grant), .load_busy (load_busy),
    .load_done (load_done), .lut_valid (lut_valid)
`ifdef SYM_VN_LUT_CHECKSUM_EN
    , .cfg_checksum (cfg_checksum), .chk_err (chk_err)
`endif
  );

  int n_tests = 0, n_fail = 0, cyc = 0;

  // Model: 0 idle, 1 waiting for reads to drain, 2 streaming, 3 final write / done.
  int         m_st, m_idx, m_iter, m_wa, m_wd, m_sum;
  bit         m_we, m_lv, m_cerr;
  logic [3:0] lut_tab [128];
  logic [3:0] bank    [128];
  bit         written [128];
  int         we_cnt, done_cyc, start_cyc, busy_cnt, abort_at, chk_tgt;
  bit         done_seen, spam;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_idx = 0; m_iter = 0; m_we = 0; m_lv = 0; m_cerr = 0; m_sum = 0;
  endtask

  task automatic model_adv();
    bit hs, ab;
    if (!rstn) begin m_reset(); return; end
    hs = (m_st == 2) && cfg_valid;
    ab = load_abort && (m_st == 1 || m_st == 2);
    m_we = hs && !ab;
    if (m_we) begin m_wa = m_idx; m_wd = int'(cfg_data); end
    if (hs) m_sum = (m_sum + int'(cfg_data)) % 2048;
    case (m_st)
      0: if (load_start) begin
           m_st = 1; m_iter = int'(load_iter); m_lv = 0; m_idx = 0; m_sum = 0; m_cerr = 0;
         end
      1: if (ab) m_st = 0; else if (!rd_busy) m_st = 2;
      2: if (ab) m_st = 0;
         else if (hs) begin if (m_idx == 127) m_st = 3; else m_idx++; end
      default: begin
`ifdef SYM_VN_LUT_CHECKSUM_EN
        if (m_sum == chk_tgt) m_lv = 1; else m_cerr = 1;
`else
        m_lv = 1;
`endif
        m_st = 0;
      end
    endcase
  endtask

  // One cycle: compare outputs settled from the last edge, drive the next inputs, step the model.
  task automatic step(input int vprob, input bit d_start, input int d_iter);
    @(negedge write_clk);
    cyc++;
    chk("rd_grant",  rd_grant,  m_st == 0);
    chk("load_busy", load_busy, m_st != 0);
    chk("cfg_ready", cfg_ready, m_st == 2);
    chk("load_done", load_done, m_st == 3);
    chk("we",        we,        m_we);
    chk("lut_valid", lut_valid, m_lv);
    chk("cfg_iter",  cfg_iter,  m_iter);
    chk("grant_and_we", we & rd_grant, 0);
    if (m_st == 2) chk("cfg_addr", cfg_addr, m_idx);
    if (m_we) begin
      chk("write_addr", write_addr, m_wa);
      chk("lut_in",     lut_in,     m_wd);
    end
`ifdef SYM_VN_LUT_CHECKSUM_EN
    chk("chk_err", chk_err, m_cerr);
`endif
    if (we) begin we_cnt++; bank[write_addr] = lut_in; written[write_addr] = 1; end
    if (load_done) begin done_seen = 1; done_cyc = cyc; end

    load_start = d_start;
    load_iter  = 5'(d_iter);
    if (spam && m_st != 0 && $urandom_range(15) == 0) begin
      load_start = 1'b1;
      load_iter  = 5'($urandom);
    end
    rd_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    cfg_valid  = ($urandom_range(99) < vprob);
    cfg_data   = (m_st == 2) ? lut_tab[m_idx] : 4'($urandom);
    load_abort = (abort_at >= 0 && m_st == 2 && m_idx == abort_at) ||
                 (m_st == 0 && !load_start && $urandom_range(7) == 0);
    model_adv();
  endtask

  task automatic run_load(input int iter, input int vprob, input int busy, input bit rnd_data,
                          input int rst_at, input int chk_off);
    int s;
    we_cnt = 0; done_seen = 0; done_cyc = 0;
    s = 0;
    for (int i = 0; i < 128; i++) begin
      lut_tab[i] = rnd_data ? 4'($urandom) : 4'(i);
      written[i] = 0;
      s += int'(lut_tab[i]);
    end
    chk_tgt = (s + chk_off) % 2048;
`ifdef SYM_VN_LUT_CHECKSUM_EN
    cfg_checksum = 11'(chk_tgt);
`endif
    busy_cnt = busy + 1;
    step(vprob, 1'b1, iter);
    start_cyc = cyc;
    for (int n = 0; n < 3000; n++) begin
      step(vprob, 1'b0, 0);
      if (rst_at >= 0 && m_st == 2 && m_idx == rst_at) begin
        #2 rstn = 1'b0;
        #1;
        chk("rst_we", we, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_lut_valid", lut_valid, 0);
        chk("rst_rd_grant", rd_grant, 1);
        chk("rst_load_busy", load_busy, 0);
        m_reset();
        step(vprob, 1'b0, 0);
        step(vprob, 1'b0, 0);
        rstn = 1'b1;
        break;
      end
      if (m_st == 0) break;
      if (n == 2999) chk("load_timeout", 1, 0);
    end
    step(vprob, 1'b0, 0);
  endtask

  task automatic chk_bank();
    for (int i = 0; i < 128; i++) chk("bank_img", {written[i], bank[i]}, {1'b1, lut_tab[i]});
  endtask

  initial begin
    rstn = 1'b0; load_start = 0; load_abort = 0; rd_busy = 0; cfg_valid = 0;
    load_iter = 0; cfg_data = 0; abort_at = -1; spam = 0; chk_tgt = 0;
`ifdef SYM_VN_LUT_CHECKSUM_EN
    cfg_checksum = '0;
`endif
    m_reset();
    repeat (3) @(negedge write_clk);
    chk("reset_we", we, 0);           chk("reset_write_addr", write_addr, 0);
    chk("reset_lut_in", lut_in, 0);   chk("reset_cfg_ready", cfg_ready, 0);
    chk("reset_cfg_addr", cfg_addr, 0); chk("reset_cfg_iter", cfg_iter, 0);
    chk("reset_rd_grant", rd_grant, 1); chk("reset_load_busy", load_busy, 0);
    chk("reset_load_done", load_done, 0); chk("reset_lut_valid", lut_valid, 0);
    rstn = 1'b1;

    // Basic: iter 3, stream always valid, data = index.
    run_load(3, 100, 0, 0, -1, 0);
    chk("basic_cfg_iter", cfg_iter, 3);
    chk("basic_we_count", we_cnt, 128);
    chk("basic_done_latency", done_cyc - start_cyc, 130);
    chk("basic_lut_valid", lut_valid, 1);
    chk("basic_rd_grant_after", rd_grant, 1);
    chk_bank();

    // Backpressure gaps with random data, plus ignored load_start pulses while busy.
    spam = 1;
    run_load(int'($urandom_range(31)), 50, 0, 1, -1, 0);
    spam = 0;
    chk("gaps_we_count", we_cnt, 128);
    chk("gaps_done", done_seen, 1);
    chk_bank();

    // Reads still in flight for 10 cycles after load_start.
    run_load(7, 100, 10, 1, -1, 0);
    chk("drain_done_latency", done_cyc - start_cyc, 140);
    chk_bank();

    // Abort after 50 accepted words; the word accepted with the abort is dropped.
    abort_at = 50;
    run_load(9, 100, 0, 1, -1, 0);
    chk("abort_we_count", we_cnt, 50);
    chk("abort_no_done", done_seen, 0);
    chk("abort_lut_valid", lut_valid, 0);
    // Abort coinciding with the final handshake wins.
    abort_at = 127;
    run_load(10, 100, 0, 1, -1, 0);
    chk("abort_last_we_count", we_cnt, 127);
    chk("abort_last_no_done", done_seen, 0);
    abort_at = -1;

    // Restart after abort begins again at address 0 and completes.
    run_load(11, 70, 2, 1, -1, 0);
    chk("restart_we_count", we_cnt, 128);
    chk_bank();

    // Asynchronous reset mid-stream, then a clean reload.
    run_load(12, 80, 0, 1, 40, 0);
    chk("rst_idle_after", load_busy, 0);
    run_load(13, 100, 0, 1, -1, 0);
    chk("post_rst_lut_valid", lut_valid, 1);

`ifdef SYM_VN_LUT_CHECKSUM_EN
    run_load(14, 60, 0, 1, -1, 1);
    chk("chk_bad_err", chk_err, 1);
    chk("chk_bad_lut_valid", lut_valid, 0);
    chk("chk_bad_done", done_seen, 1);
    run_load(15, 60, 0, 1, -1, 0);
    chk("chk_good_err", chk_err, 0);
    chk("chk_good_lut_valid", lut_valid, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
